argmax_scan: RTL

Parametrised argmax engine for the classifier output stage: it captures a packed vector of `numInput` neuron outputs, then scans `numLanes` elements per clock. It reports the index and value of the largest element, with optional signed comparison and an optional runner-up result. It sits after the last dense layer and feeds the result/interrupt register block. It is the multi-lane, signed-capable, handshaked generalisation of the single-lane max finder.

---
 rtl/argmax_scan.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/argmax_scan.sv
// rtl/argmax_scan.sv - multi-lane argmax engine over a captured packed vector
//
// Captures numInput elements of inputWidth bits on an i_valid/o_ready
// handshake, then compares numLanes elements per clock against the running
// best. After ceil(numInput/numLanes) scan cycles the index and value of the
// largest element are loaded into o_data/o_max_value and o_data_valid pulses.
// Ties resolve to the lowest index. isSigned selects two's complement compare.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_data, i_valid    packed input vector, element k at [k*inputWidth +: inputWidth]
//   o_ready            idle, a vector presented with i_valid is taken this cycle
//   o_data             index of the maximum element, zero-extended to 32 bits
//   o_max_value        value of the maximum element
//   o_data_valid       one-cycle pulse, result outputs updated
//   o_second_data      runner-up index      (ARGMAX_TOP2_EN only)
//   o_second_value     runner-up value      (ARGMAX_TOP2_EN only)
//
// Build option: define ARGMAX_TOP2_EN to add the runner-up outputs.

module argmax_scan #(
    parameter int numInput   = 10,
    parameter int inputWidth = 16,
    parameter int numLanes   = 1,
    parameter int isSigned   = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [numInput*inputWidth-1:0] i_data,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic [31:0]                    o_data,
    output logic [inputWidth-1:0]          o_max_value,
    output logic                           o_data_valid
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [31:0]                    o_second_data,
    output logic [inputWidth-1:0]          o_second_value
`endif
);

    localparam int W    = inputWidth;
    localparam int G    = (numInput + numLanes - 1) / numLanes;
    localparam int GW   = numLanes * W;
    localparam int PADW = G * GW;
`ifdef ARGMAX_TOP2_EN
    // Elements 0 and 1 seed best/second at capture, so lanes never revisit them.
    localparam int INIT_N = 2;
`else
    localparam int INIT_N = 1;
`endif

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Buffer is padded to a whole number of groups and shifted down one group
    // per scan cycle, so the current group always sits in the low GW bits.
    logic [PADW-1:0] vec_buf;
    logic [31:0]     grp_cnt;
    logic [31:0]     base_idx;
    logic [W-1:0]    best_val;
    logic [31:0]     best_idx;
    logic [W-1:0]    nxt_best_val;
    logic [31:0]     nxt_best_idx;
    logic            accept;
    logic            last_grp;

    logic            c1_vld;
    logic [W-1:0]    c1_val;
    logic [31:0]     c1_idx;
    logic [W-1:0]    lane_val;
    logic [31:0]     lane_idx;
    logic            lane_ok;

`ifdef ARGMAX_TOP2_EN
    logic [W-1:0]    sec_val;
    logic [31:0]     sec_idx;
    logic [W-1:0]    nxt_sec_val;
    logic [31:0]     nxt_sec_idx;
    logic            c2_vld;
    logic [W-1:0]    c2_val;
    logic [31:0]     c2_idx;
    logic [W-1:0]    elem0;
    logic [W-1:0]    elem1;

    assign elem0 = i_data[W-1:0];
    assign elem1 = i_data[2*W-1:W];
`endif

    function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
        if (isSigned != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_grp  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (grp_cnt == 32'(G - 1)) begin
                    last_grp  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_ready = (state == S_IDLE);

    // In-group reduction. Lanes are visited in ascending index and only a
    // strictly greater lane displaces the leader, so equal values keep the
    // lower index. Padding lanes and already-seeded elements are masked.
    always_comb begin
        c1_vld   = 1'b0;
        c1_val   = '0;
        c1_idx   = '0;
`ifdef ARGMAX_TOP2_EN
        c2_vld   = 1'b0;
        c2_val   = '0;
        c2_idx   = '0;
`endif
        lane_val = '0;
        lane_idx = '0;
        lane_ok  = 1'b0;
        for (int l = 0; l < numLanes; l++) begin
            lane_val = vec_buf[l*W +: W];
            lane_idx = base_idx + 32'(l);
            lane_ok  = (lane_idx < 32'(numInput)) && (lane_idx >= 32'(INIT_N));
            if (lane_ok) begin
                if (!c1_vld || gt(lane_val, c1_val)) begin
`ifdef ARGMAX_TOP2_EN
                    c2_vld = c1_vld;
                    c2_val = c1_val;
                    c2_idx = c1_idx;
`endif
                    c1_vld = 1'b1;
                    c1_val = lane_val;
                    c1_idx = lane_idx;
                end
`ifdef ARGMAX_TOP2_EN
                else if (!c2_vld || gt(lane_val, c2_val)) begin
                    c2_vld = 1'b1;
                    c2_val = lane_val;
                    c2_idx = lane_idx;
                end
`endif
            end
        end
    end

    // Merge with the running result. Every group index exceeds every index
    // already held, so on equality the held entry always wins.
    always_comb begin
        nxt_best_val = best_val;
        nxt_best_idx = best_idx;
`ifdef ARGMAX_TOP2_EN
        nxt_sec_val  = sec_val;
        nxt_sec_idx  = sec_idx;
        if (c1_vld && gt(c1_val, best_val)) begin
            nxt_best_val = c1_val;
            nxt_best_idx = c1_idx;
            // The displaced best competes with the group runner-up; the old
            // second is no larger than the old best so it drops out.
            if (c2_vld && gt(c2_val, best_val)) begin
                nxt_sec_val = c2_val;
                nxt_sec_idx = c2_idx;
            end else begin
                nxt_sec_val = best_val;
                nxt_sec_idx = best_idx;
            end
        end else if (c1_vld && gt(c1_val, sec_val)) begin
            nxt_sec_val = c1_val;
            nxt_sec_idx = c1_idx;
        end
`else
        if (c1_vld && gt(c1_val, best_val)) begin
            nxt_best_val = c1_val;
            nxt_best_idx = c1_idx;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vec_buf        <= '0;
            grp_cnt        <= '0;
            base_idx       <= '0;
            best_val       <= '0;
            best_idx       <= '0;
            o_data         <= '0;
            o_max_value    <= '0;
            o_data_valid   <= 1'b0;
`ifdef ARGMAX_TOP2_EN
            sec_val        <= '0;
            sec_idx        <= '0;
            o_second_data  <= '0;
            o_second_value <= '0;
`endif
        end else begin
            o_data_valid <= 1'b0;
            if (accept) begin
                vec_buf  <= PADW'(i_data);
                grp_cnt  <= '0;
                base_idx <= '0;
`ifdef ARGMAX_TOP2_EN
                if (gt(elem1, elem0)) begin
                    best_val <= elem1;
                    best_idx <= 32'd1;
                    sec_val  <= elem0;
                    sec_idx  <= 32'd0;
                end else begin
                    best_val <= elem0;
                    best_idx <= 32'd0;
                    sec_val  <= elem1;
                    sec_idx  <= 32'd1;
                end
`else
                best_val <= i_data[W-1:0];
                best_idx <= 32'd0;
`endif
            end else if (state == S_SCAN) begin
                vec_buf  <= vec_buf >> GW;
                grp_cnt  <= grp_cnt + 32'd1;
                base_idx <= base_idx + 32'(numLanes);
                best_val <= nxt_best_val;
                best_idx <= nxt_best_idx;
`ifdef ARGMAX_TOP2_EN
                sec_val  <= nxt_sec_val;
                sec_idx  <= nxt_sec_idx;
`endif
                if (last_grp) begin
                    o_data       <= nxt_best_idx;
                    o_max_value  <= nxt_best_val;
                    o_data_valid <= 1'b1;
`ifdef ARGMAX_TOP2_EN
                    o_second_data  <= nxt_sec_idx;
                    o_second_value <= nxt_sec_val;
`endif
                end
            end
        end
    end

endmodule
